// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions for the AES datapath: field width,
// reduction polynomial and the multiplier's control states.
package gf_pkg;

  localparam int GF_W = 8;
  localparam logic [GF_W-1:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x in GF(2^8) with reduction by POLY;
// shared with MixColumns.
module gf_xtime
  import gf_pkg::*;
#(
  parameter logic [GF_W-1:0] POLY = AES_POLY
) (
  input  logic [GF_W-1:0] a,
  output logic [GF_W-1:0] y
);

  assign y = {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? POLY : '0);

endmodule

// File: rtl/top_gf_mul.sv
// Iterative shift-and-add GF(2^8) multiplier, one multiplier bit per clock,
// with a level-sensitive en / o_done handshake.
module top_gf_mul
  import gf_pkg::*;
#(
  parameter logic [GF_W-1:0] POLY = AES_POLY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [GF_W-1:0] i_state_1,
  input  logic [GF_W-1:0] i_state_2,
  output logic [GF_W-1:0] o_state,
  output logic            o_done
);

  state_t          state;
  state_t          state_next;
  logic [GF_W-1:0] a;
  logic [GF_W-1:0] b;
  logic [GF_W-1:0] p;
  logic [2:0]      count;
  logic [GF_W-1:0] a_x;
  logic [GF_W-1:0] p_iter;

  gf_xtime #(.POLY(POLY)) u_xtime (
    .a (a),
    .y (a_x)
  );

  always_comb begin
    state_next = state;
    p_iter     = b[0] ? (p ^ a) : p;
    case (state)
      IDLE:    if (en) state_next = CALC;
      CALC:    if (count == 3'd7) state_next = DONE;
      DONE:    if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands are captured only on the IDLE->CALC edge; the last product is
  // kept on o_state after o_done falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      p       <= '0;
      count   <= '0;
      o_state <= '0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a     <= i_state_1;
            b     <= i_state_2;
            p     <= '0;
            count <= '0;
          end
        end
        CALC: begin
          p     <= p_iter;
          a     <= a_x;
          b     <= b >> 1;
          count <= count + 3'd1;
          if (count == 3'd7) begin
            o_state <= p_iter;
            o_done  <= 1'b1;
          end
        end
        DONE: begin
          if (!en) o_done <= 1'b0;
        end
        default: o_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_top_gf_mul.sv
// Directed bench for top_gf_mul with hand-computed AES field products.
module tb_top_gf_mul;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] i_state_1;
  logic [7:0] i_state_2;
  logic [7:0] o_state;
  logic       o_done;

  int n_checks;
  int n_pass;

  top_gf_mul dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i_state_1 (i_state_1),
    .i_state_2 (i_state_2),
    .o_state   (o_state),
    .o_done    (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Start at E0, expect the product after E8, then drop en for one edge.
  task automatic run_mul(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp, input string tag);
    i_state_1 = x;
    i_state_2 = y;
    en = 1'b1;
    tick();
    repeat (7) tick();
    check({tag, "_done_early"}, o_done, 1'b0);
    tick();
    check({tag, "_done"}, o_done, 1'b1);
    check({tag, "_prod"}, o_state, exp);
    en = 1'b0;
    tick();
    check({tag, "_idle"}, o_done, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    i_state_1 = 8'h00;
    i_state_2 = 8'h00;

    // Reset
    tick();
    check("rst_done_0", o_done, 1'b0);
    check("rst_state_0", o_state, 8'h00);
    tick();
    check("rst_done_1", o_done, 1'b0);
    check("rst_state_1", o_state, 8'h00);
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("idle_done", o_done, 1'b0);
    end

    // Held request: single computation, stable result
    i_state_1 = 8'h26;
    i_state_2 = 8'h9E;
    en = 1'b1;
    tick();
    repeat (7) tick();
    check("hold_done_e7", o_done, 1'b0);
    tick();
    check("hold_done_e8", o_done, 1'b1);
    check("hold_prod", o_state, 8'h2F);
    repeat (5) begin
      tick();
      check("hold_done_stable", o_done, 1'b1);
      check("hold_prod_stable", o_state, 8'h2F);
    end
    en = 1'b0;
    tick();
    check("hold_release_done", o_done, 1'b0);
    check("hold_release_keep", o_state, 8'h2F);

    // Known products
    run_mul(8'h57, 8'h83, 8'hC1, "p57x83");
    run_mul(8'h57, 8'h13, 8'hFE, "p57x13");
    run_mul(8'h02, 8'h80, 8'h1B, "p02x80");
    run_mul(8'h01, 8'hAB, 8'hAB, "p01xAB");
    run_mul(8'h00, 8'hFF, 8'h00, "p00xFF");
    run_mul(8'hFF, 8'hFF, 8'h13, "pFFxFF");

    // Operand change mid-CALC is ignored
    i_state_1 = 8'h57;
    i_state_2 = 8'h83;
    en = 1'b1;
    tick();
    repeat (3) tick();
    i_state_1 = 8'h00;
    i_state_2 = 8'h00;
    repeat (4) tick();
    check("opchg_done_e7", o_done, 1'b0);
    tick();
    check("opchg_done", o_done, 1'b1);
    check("opchg_prod", o_state, 8'hC1);
    en = 1'b0;
    tick();
    check("opchg_idle", o_done, 1'b0);

    // en dropped during CALC: one-cycle done pulse
    i_state_1 = 8'h57;
    i_state_2 = 8'h13;
    en = 1'b1;
    tick();
    repeat (4) tick();
    en = 1'b0;
    repeat (3) tick();
    check("drop_done_e7", o_done, 1'b0);
    tick();
    check("drop_done", o_done, 1'b1);
    check("drop_prod", o_state, 8'hFE);
    tick();
    check("drop_pulse_end", o_done, 1'b0);
    check("drop_keep", o_state, 8'hFE);
    repeat (9) tick();
    check("drop_stays_idle", o_done, 1'b0);

    // Reset mid-CALC aborts, then a fresh request completes
    i_state_1 = 8'hFF;
    i_state_2 = 8'hFF;
    en = 1'b1;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("abort_done", o_done, 1'b0);
    check("abort_state", o_state, 8'h00);
    rst = 1'b0;
    en  = 1'b0;
    tick();
    check("abort_idle", o_done, 1'b0);
    run_mul(8'h26, 8'h9E, 8'h2F, "fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
